// File: rtl/scope_pkg.sv
// scope_pkg: shared capture state encoding, settle depth and default widths
package scope_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, PRE, WAIT_TRIG, POST, DONE} cap_state_t;
  localparam int SETTLE_TICKS = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if: sample RAM write port between capture controller and RAM
interface adc_capture_ctrl_if
  import scope_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave (input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/adc_clk_gen.sv
// adc_clk_gen: programmable ADC clock divider with a falling-edge sample tick
module adc_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_adc_clk,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt, r_div;
  logic w_tc;
  assign w_tc = r_cnt == r_div;
  assign o_tick = w_tc & o_adc_clk;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
      o_adc_clk <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_div <= i_div;
      o_adc_clk <= ~o_adc_clk;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered scope ADC acquisition into a circular sample RAM
module adc_capture_ctrl
  import scope_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIV_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_trig_rising,
  input  logic              i_trig_force,
  input  logic [ADDR_W-1:0] i_pre_samples,
  input  logic [DATA_W-1:0] i_adc_d,
  output logic              o_adc_clk,
  output logic              o_adc_noe,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_addr,
  adc_capture_ctrl_if.master wr_if
);
  cap_state_t r_state;
  logic [ADDR_W-1:0] r_pre, r_ptr, r_cnt, r_wr_addr, r_trig_addr;
  logic [DATA_W-1:0] r_prev, r_wr_data;
  logic r_prev_valid, r_wr_en, r_busy, r_done, r_noe;
  logic w_tick, w_trig, w_cap, w_last;
  adc_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_div(i_clk_div),
    .o_adc_clk(o_adc_clk),
    .o_tick(w_tick)
  );
  assign w_trig = i_trig_force | (r_prev_valid & (i_trig_rising
    ? (r_prev < i_trig_level && i_adc_d >= i_trig_level)
    : (r_prev > i_trig_level && i_adc_d <= i_trig_level)));
  assign w_cap = r_state inside {PRE, WAIT_TRIG, POST};
  assign w_last = (r_state == WAIT_TRIG && w_trig && &r_pre) || (r_state == POST && r_cnt == ADDR_W'(1));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pre <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_wr_addr <= '0;
      r_trig_addr <= '0;
      r_prev <= '0;
      r_wr_data <= '0;
      r_prev_valid <= 1'b0;
      r_wr_en <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_noe <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
        r_done <= 1'b0;
        r_noe <= 1'b1;
      end else if (i_arm && (r_state == IDLE || r_state == DONE)) begin
        r_state <= SETTLE;
        r_pre <= i_pre_samples;
        r_ptr <= '0;
        r_cnt <= '0;
        r_prev_valid <= 1'b0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_noe <= 1'b0;
      end else if (w_tick && r_state == SETTLE) begin
        r_cnt <= (r_cnt == ADDR_W'(SETTLE_TICKS - 1)) ? '0 : r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(SETTLE_TICKS - 1)) r_state <= (r_pre == '0) ? WAIT_TRIG : PRE;
      end else if (w_tick && w_cap) begin
        r_wr_en <= 1'b1;
        r_wr_addr <= r_ptr;
        r_wr_data <= i_adc_d;
        r_ptr <= r_ptr + ADDR_W'(1);
        r_prev <= i_adc_d;
        r_prev_valid <= 1'b1;
        if (r_state == PRE) begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt + ADDR_W'(1) == r_pre) r_state <= WAIT_TRIG;
        end else if (r_state == WAIT_TRIG && w_trig) begin
          r_trig_addr <= r_ptr;
          r_cnt <= ~r_pre;
          r_state <= POST;
        end else if (r_state == POST) begin
          r_cnt <= r_cnt - ADDR_W'(1);
        end
        if (w_last) begin
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_noe <= 1'b1;
        end
      end
    end
  end
  assign o_adc_noe = r_noe;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_trig_addr = r_trig_addr;
  assign wr_if.wr_en = r_wr_en;
  assign wr_if.wr_addr = r_wr_addr;
  assign wr_if.wr_data = r_wr_data;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for the triggered ADC capture controller
module tb_adc_capture_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int VW = 8;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit first;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic trig_rising = 1'b1;
  logic trig_force = 1'b0;
  logic [VW-1:0] clk_div = 8'd4;
  logic [DW-1:0] trig_level = 8'h80;
  logic [DW-1:0] adc_d = '0;
  logic [AW-1:0] pre_samples = '0;
  logic [AW-1:0] trig_addr;
  logic adc_clk, adc_noe, busy, done;
  logic [DW-1:0] tbl [64];
  logic [DW-1:0] ram [16];
  wr_t exp_q [$];
  wr_t mon_e;
  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int cyc = 0;
  int last_wr = 0;
  int exp_gap = 10;
  int acnt = 0;
  int base = 0;
  int n0, th, tl;
  adc_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) wr_if ();
  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DIV_W(VW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_arm(arm),
    .i_abort(abort),
    .i_clk_div(clk_div),
    .i_trig_level(trig_level),
    .i_trig_rising(trig_rising),
    .i_trig_force(trig_force),
    .i_pre_samples(pre_samples),
    .i_adc_d(adc_d),
    .o_adc_clk(adc_clk),
    .o_adc_noe(adc_noe),
    .o_busy(busy),
    .o_done(done),
    .o_trig_addr(trig_addr),
    .wr_if(wr_if)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int idx;
    forever begin
      @(posedge adc_clk);
      #1;
      idx = acnt - base;
      adc_d = tbl[idx > 63 ? 63 : idx];
      acnt++;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_if.wr_en === 1'b1) begin
        nwr++;
        ram[wr_if.wr_addr] = wr_if.wr_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%02h", wr_if.wr_addr, wr_if.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_if.wr_addr !== mon_e.a || wr_if.wr_data !== mon_e.d) begin
            errors++;
            $display("FAIL write got addr=%0d data=%02h want addr=%0d data=%02h", wr_if.wr_addr, wr_if.wr_data, mon_e.a, mon_e.d);
          end
          if (!mon_e.first) begin
            checks++;
            if (cyc - last_wr != exp_gap) begin
              errors++;
              $display("FAIL write_gap got %0d want %0d", cyc - last_wr, exp_gap);
            end
          end
        end
        last_wr = cyc;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  task automatic push(input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.a = AW'(k);
      e.d = tbl[2 + k];
      e.first = (k == 0);
      exp_q.push_back(e);
    end
  endtask
  task automatic do_arm();
    logic p, c;
    int t = 0;
    c = adc_clk;
    do begin
      p = c;
      @(negedge clk);
      c = adc_clk;
      t++;
    end while (!(p && !c) && t < 1000);
    if (t >= 1000) chk("arm_align_timeout", t, 0);
    arm = 1'b1;
    base = acnt;
    @(negedge clk);
    arm = 1'b0;
  endtask
  task automatic wait_nwr(input int n, input int budget);
    int t = 0;
    while (nwr < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("wait_writes", nwr >= n, 1);
  endtask
  task automatic wait_done(input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_rise", done, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_level(input logic v, output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (adc_clk !== v && t < 200);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_noe", adc_noe, 1);
    chk("rst_wr_en", wr_if.wr_en, 0);
    chk("rst_wr_addr", wr_if.wr_addr, 0);
    chk("rst_wr_data", wr_if.wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    wait_level(1'b0, th);
    wait_level(1'b1, th);
    wait_level(1'b0, th);
    wait_level(1'b1, tl);
    chk("div4_high_cycles", th, 5);
    chk("div4_low_cycles", tl, 5);
    exp_gap = 10;
    tbl[0] = 8'h00;
    tbl[1] = 8'h00;
    for (int i = 2; i < 64; i++) tbl[i] = DW'(8'h50 + 8 * (i - 2));
    trig_rising = 1'b1;
    trig_level = 8'h80;
    pre_samples = 4'd4;
    push(18);
    do_arm();
    chk("t2_busy", busy, 1);
    chk("t2_noe", adc_noe, 0);
    wait_done(1000);
    chk("t2_trig_addr", trig_addr, 6);
    chk("t2_queue_left", exp_q.size(), 0);
    chk("t2_busy_done", busy, 0);
    chk("t2_noe_done", adc_noe, 1);
    chk("t2_oldest", ram[2], 8'h60);
    chk("t2_trig_sample", ram[6], 8'h80);
    clk_div = 8'd2;
    exp_gap = 6;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 64; i++) tbl[i] = (i < 6) ? 8'h80 : (i == 6) ? 8'h81 : 8'h7F;
    trig_rising = 1'b0;
    pre_samples = 4'd2;
    push(19);
    do_arm();
    chk("t3_done_cleared", done, 0);
    wait_done(1000);
    chk("t3_trig_addr", trig_addr, 5);
    chk("t3_queue_left", exp_q.size(), 0);
    chk("t3_oldest", ram[3], 8'h80);
    chk("t3_trig_sample", ram[5], 8'h7F);
    for (int i = 0; i < 64; i++) tbl[i] = DW'(8'h10 + i);
    trig_force = 1'b1;
    pre_samples = 4'd0;
    push(16);
    do_arm();
    wait_done(1000);
    chk("t4_trig_addr", trig_addr, 0);
    chk("t4_queue_left", exp_q.size(), 0);
    for (int i = 0; i < 64; i++) tbl[i] = DW'(8'hA0 + i);
    pre_samples = 4'd1;
    push(5);
    n0 = nwr;
    do_arm();
    wait_nwr(n0 + 5, 500);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("t5_busy_after_abort", busy, 0);
    chk("t5_noe_after_abort", adc_noe, 1);
    repeat (30) @(negedge clk);
    chk("t5_queue_left", exp_q.size(), 0);
    chk("t5_done_after_abort", done, 0);
    chk("t5_trig_retained", trig_addr, 1);
    for (int i = 0; i < 64; i++) tbl[i] = DW'(8'hC0 + i);
    pre_samples = 4'd0;
    push(16);
    do_arm();
    wait_done(1000);
    chk("t5_rearm_trig_addr", trig_addr, 0);
    chk("t5_rearm_queue_left", exp_q.size(), 0);
    trig_force = 1'b0;
    for (int i = 0; i < 64; i++) tbl[i] = 8'h80;
    trig_rising = 1'b1;
    pre_samples = 4'd2;
    push(6);
    n0 = nwr;
    do_arm();
    wait_nwr(n0 + 4, 500);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("t6_busy_arm_ignored", busy, 1);
    wait_nwr(n0 + 6, 500);
    th = 0;
    while (adc_clk !== 1'b1 && th < 100) begin
      @(negedge clk);
      th++;
    end
    chk("t6_adc_clk_high", adc_clk, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_adc_clk", adc_clk, 0);
    chk("t6_rst_noe", adc_noe, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wr_en", wr_if.wr_en, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_queue_left", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n0 = nwr;
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    chk("t6_arm_abort_busy", busy, 0);
    chk("t6_arm_abort_noe", adc_noe, 1);
    repeat (40) @(negedge clk);
    chk("t6_no_writes", nwr, n0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
